// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an RV32I instruction to an ALU operation and operands,
// then registers the bundle behind a single-entry valid/ready handshake toward EX.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [DATA_WIDTH-1:0]    pc,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [4:0]               rd,
  output logic                     reg_write,
  output logic                     is_branch,
  output logic                     br_invert,
  output logic                     illegal
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [OPCODE_LENGTH-1:0] AluAdd  = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] AluSub  = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] AluXor  = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] AluOr   = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] AluAnd  = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] AluSrl  = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] AluSll  = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] AluSra  = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] AluSlt  = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] AluSltu = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] AluEq   = 4'b1010;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  alt_f7;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_s;
  logic [DATA_WIDTH-1:0] imm_u;
  logic [DATA_WIDTH-1:0] shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign alt_f7 = (funct7 == 7'b0100000);
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  logic [DATA_WIDTH-1:0]    d_srca;
  logic [DATA_WIDTH-1:0]    d_srcb;
  logic [OPCODE_LENGTH-1:0] d_op;
  logic [4:0]               d_rd;
  logic                     d_rw;
  logic                     d_br;
  logic                     d_inv;
  logic                     d_ill;

  always_comb begin
    d_srca = rs1_data;
    d_srcb = rs2_data;
    d_op   = AluAdd;
    d_rd   = instr[11:7];
    d_rw   = 1'b1;
    d_br   = 1'b0;
    d_inv  = 1'b0;
    d_ill  = 1'b0;
    case (opcode)
      OpcOp: begin
        unique case (funct3)
          3'b000: d_op = alt_f7 ? AluSub : AluAdd;
          3'b001: d_op = AluSll;
          3'b010: d_op = AluSlt;
          3'b011: d_op = AluSltu;
          3'b100: d_op = AluXor;
          3'b101: d_op = alt_f7 ? AluSra : AluSrl;
          3'b110: d_op = AluOr;
          3'b111: d_op = AluAnd;
        endcase
        // Only ADD/SUB and SRL/SRA have an alternate encoding
        if (!((funct7 == 7'b0) || (alt_f7 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
          d_ill = 1'b1;
        end
      end
      OpcOpImm: begin
        d_srcb = imm_i;
        unique case (funct3)
          3'b000: d_op = AluAdd;
          3'b001: begin
            d_op   = AluSll;
            d_srcb = shamt;
            d_ill  = (funct7 != 7'b0);
          end
          3'b010: d_op = AluSlt;
          3'b011: d_op = AluSltu;
          3'b100: d_op = AluXor;
          3'b101: begin
            d_op   = instr[30] ? AluSra : AluSrl;
            d_srcb = shamt;
          end
          3'b110: d_op = AluOr;
          3'b111: d_op = AluAnd;
        endcase
      end
      OpcLui: begin
        d_srca = '0;
        d_srcb = imm_u;
      end
      OpcAuipc: begin
        d_srca = pc;
        d_srcb = imm_u;
      end
      OpcLoad: d_srcb = imm_i;
      OpcStore: begin
        d_srcb = imm_s;
        d_rd   = 5'd0;
        d_rw   = 1'b0;
      end
      OpcBranch: begin
        d_rd  = 5'd0;
        d_rw  = 1'b0;
        d_br  = 1'b1;
        d_inv = funct3[0];
        unique case (funct3[2:1])
          2'b00: d_op = AluEq;
          2'b01: d_ill = 1'b1;
          2'b10: d_op = AluSlt;
          2'b11: d_op = AluSltu;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal bundles still flow to EX, but must not write or steer a branch
    if (d_ill) begin
      d_op  = AluAdd;
      d_rw  = 1'b0;
      d_br  = 1'b0;
      d_inv = 1'b0;
    end
    if (d_rd == 5'd0) d_rw = 1'b0;
  end

  logic accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      SrcA      <= '0;
      SrcB      <= '0;
      Operation <= '0;
      rd        <= '0;
      reg_write <= 1'b0;
      is_branch <= 1'b0;
      br_invert <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      SrcA      <= d_srca;
      SrcB      <= d_srcb;
      Operation <= d_op;
      rd        <= d_rd;
      reg_write <= d_rw;
      is_branch <= d_br;
      br_invert <= d_inv;
      illegal   <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios then random traffic checked against a
// field-level reference decoder and a one-entry occupancy model.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic [4:0]  rd;
  logic        reg_write;
  logic        is_branch;
  logic        br_invert;
  logic        illegal;

  alu_issue_stage #(
    .DATA_WIDTH   (32),
    .OPCODE_LENGTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Operation(Operation),
    .rd       (rd),
    .reg_write(reg_write),
    .is_branch(is_branch),
    .br_invert(br_invert),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        inv;
    logic        ill;
  } bundle_t;

  // ALU code per funct3 for the plain (non-alternate) OP/OP-IMM encodings, index 7 first
  localparam logic [31:0] OpTbl = {4'h4, 4'h3, 4'h5, 4'h2, 4'h9, 4'h8, 4'h6, 4'h0};

  int      tests;
  int      failed;
  logic    m_valid;
  bundle_t m_b;

  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                         input logic [31:0] r1, input logic [31:0] r2);
    bundle_t     b;
    logic [2:0]  f3    = ins[14:12];
    logic [6:0]  f7    = ins[31:25];
    logic [31:0] imm_i = 32'($signed(ins) >>> 20);
    logic [31:0] imm_s = (imm_i & ~32'h1F) | 32'(ins[11:7]);
    logic [31:0] imm_u = ins & 32'hFFFF_F000;
    b    = '0;
    b.a  = r1;
    b.b  = r2;
    b.rd = ins[11:7];
    b.rw = 1'b1;
    case (ins[6:0])
      7'h33: begin
        b.op  = OpTbl[{f3, 2'b00} +: 4];
        if (f7 == 7'h20 && f3 == 3'd0) b.op = 4'b0001;
        if (f7 == 7'h20 && f3 == 3'd5) b.op = 4'b0111;
        b.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        b.b   = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : imm_i;
        b.op  = OpTbl[{f3, 2'b00} +: 4];
        if (f3 == 3'd5 && ins[30]) b.op = 4'b0111;
        b.ill = (f3 == 3'd1) && (f7 != 7'h00);
      end
      7'h37: begin b.a = 32'd0; b.b = imm_u; end
      7'h17: begin b.a = pcv; b.b = imm_u; end
      7'h03: b.b = imm_i;
      7'h23: begin b.b = imm_s; b.rd = 5'd0; b.rw = 1'b0; end
      7'h63: begin
        b.rd  = 5'd0;
        b.rw  = 1'b0;
        b.br  = 1'b1;
        b.inv = f3[0];
        b.op  = (f3 < 3'd4) ? 4'b1010 : ((f3 < 3'd6) ? 4'b1000 : 4'b1001);
        b.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      default: b.ill = 1'b1;
    endcase
    if (b.ill) begin
      b.op = 4'd0;
      b.rw = 1'b0;
    end
    if (b.rd == 5'd0) b.rw = 1'b0;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  opc;
    case ($urandom_range(0, 9))
      0, 1:    opc = 7'h33;
      2, 3:    opc = 7'h13;
      4:       opc = 7'h37;
      5:       opc = 7'h17;
      6:       opc = 7'h03;
      7:       opc = 7'h23;
      8:       opc = 7'h63;
      default: opc = ($urandom_range(0, 1) == 0) ? 7'h73 : 7'h6F;
    endcase
    if (opc == 7'h33 || opc == 7'h13) begin
      case ($urandom_range(0, 3))
        0, 1:    w[31:25] = 7'h00;
        2:       w[31:25] = 7'h20;
        default: ;
      endcase
    end
    w[6:0] = opc;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("Operation", 32'(Operation), 32'(m_b.op));
      check("illegal", 32'(illegal), 32'(m_b.ill));
      check("reg_write", 32'(reg_write), 32'(m_b.rw));
      if (!m_b.ill) begin
        check("SrcA", SrcA, m_b.a);
        check("SrcB", SrcB, m_b.b);
        check("rd", 32'(rd), 32'(m_b.rd));
        check("is_branch", 32'(is_branch), 32'(m_b.br));
        check("br_invert", 32'(br_invert), 32'(m_b.inv));
      end
    end
  endtask

  // One clock: drive, check in_ready, clock, advance the model, check outputs
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
    logic rdy;
    in_valid  = v;
    instr     = ins;
    pc        = pcv;
    rs1_data  = r1;
    rs2_data  = r2;
    out_ready = ordy;
    flush     = fl;
    rdy       = !m_valid || ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (v && rdy) begin
      m_valid = 1'b1;
      m_b     = ref_decode(ins, pcv, r1, r2);
    end else if (ordy) m_valid = 1'b0;
    #1;
    check_outputs();
  endtask

  logic [31:0] held_a;

  initial begin
    tests     = 0;
    failed    = 0;
    m_valid   = 1'b0;
    m_b       = '0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'h0;
    pc        = 32'h0;
    rs1_data  = 32'h0;
    rs2_data  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_SrcA", SrcA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD x3,x1,x2 held with out_ready low
    cycle(1'b1, 32'h002081B3, 32'h40, 32'd5, 32'd7, 1'b0, 1'b0);
    check("t2_SrcA", SrcA, 32'd5);
    check("t2_SrcB", SrcB, 32'd7);
    check("t2_op", 32'(Operation), 32'd0);
    check("t2_rd", 32'(rd), 32'd3);
    check("t2_rw", 32'(reg_write), 32'd1);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset while a bundle is held
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_SrcA", SrcA, 32'd0);
    check("t1_SrcB", SrcB, 32'd0);
    check("t1_op_rd_rw", {Operation, rd, reg_write, is_branch, br_invert, illegal}, 32'd0);
    #1;
    rst_n = 1'b1;

    cycle(1'b1, 32'h4030D213, 32'h0, 32'hF000_0000, 32'h0, 1'b1, 1'b0);
    check("t3_srai_SrcB", SrcB, 32'd3);
    check("t3_srai_op", 32'(Operation), 32'd7);
    cycle(1'b1, 32'hFFF00093, 32'h0, 32'd9, 32'h0, 1'b1, 1'b0);
    check("t3_addi_SrcB", SrcB, 32'hFFFF_FFFF);
    check("t3_addi_op", 32'(Operation), 32'd0);

    cycle(1'b1, 32'h0020F063, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
    check("t4_op", 32'(Operation), 32'd9);
    check("t4_br", {is_branch, br_invert}, 32'd3);
    check("t4_rd_rw", {rd, reg_write}, 32'd0);
    cycle(1'b1, 32'h0020A063, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
    check("t4_illegal", 32'(illegal), 32'd1);

    // Stall three cycles, then release with the next instruction loaded on the same edge
    cycle(1'b1, 32'h00208233, 32'h0, 32'hAAAA_0001, 32'h1, 1'b1, 1'b0);
    held_a = SrcA;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h402082B3, 32'h0, 32'h5555_0002, 32'h2, 1'b0, 1'b0);
      check("t5_frozen", SrcA, held_a);
    end
    cycle(1'b1, 32'h402082B3, 32'h0, 32'h5555_0002, 32'h2, 1'b1, 1'b0);
    check("t5_next_valid", 32'(out_valid), 32'd1);
    check("t5_next_SrcA", SrcA, 32'h5555_0002);
    check("t5_next_op", 32'(Operation), 32'd1);

    cycle(1'b1, 32'h00208233, 32'h0, 32'h1, 32'h2, 1'b1, 1'b1);
    check("t6_flush", 32'(out_valid), 32'd0);
    cycle(1'b1, 32'h00001297, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
    check("t6_auipc_SrcA", SrcA, 32'h100);
    check("t6_auipc_SrcB", SrcB, 32'h1000);

    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
